// File: rtl/fft_frame_sequencer.sv
// ---------------------------------------------------------------------------
// fft_frame_sequencer
//
// Purpose:
//   Front/back-end sequencer for the radix-2 FFT core in the MFCC chain.
//   A windowed sample stream is written into the FFT buffer in natural
//   order. The frame is zero-padded up to NFFT, the FFT is started, and new
//   input is blocked while the FFT computes. The power bins coming back from
//   the FFT are re-emitted with a frame tag and a last-bin flag for the mel
//   filterbank.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   enable_i            allows a new frame to begin (sampled in IDLE and at done)
//   s_valid_i/s_data_i  windowed sample stream in
//   s_ready_o           high for the whole LOAD phase
//   fft_in_valid_o      FFT buffer write strobe
//   fft_frame_ptr_o     natural-order buffer write index
//   fft_real_o          buffer write data (0 while padding)
//   fft_start_o         one-cycle start pulse after the final buffer write
//   fft_done_i          FFT done pulse (only honoured in WAIT_DONE)
//   fft_power_*_i       power bins from the FFT
//   pw_*_o              registered, tagged power bins (bins above NFFT/2 dropped)
//   busy_o              sequencer is not idle
//   frame_done_o        one-cycle pulse per completed frame
//   timeout_o           sticky watchdog flag
//
// Configuration:
//   FFT_SEQ_WATCHDOG_EN  when defined, a watchdog aborts WAIT_DONE after
//                        TIMEOUT_CYCLES cycles without fft_done_i. When not
//                        defined, timeout_o is tied low and no counter exists.
// ---------------------------------------------------------------------------
module fft_frame_sequencer #(
  parameter int unsigned NFFT           = 512,
  parameter int unsigned NFFT_LOG2      = $clog2(NFFT),
  parameter int unsigned FRAME_LEN      = 400,
  parameter int unsigned INPUT_WIDTH    = 16,
  parameter int unsigned COMPLEX_WIDTH  = 32,
  parameter int unsigned FRAME_ID_W     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 8192
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable_i,
  input  logic                     s_valid_i,
  input  logic [INPUT_WIDTH-1:0]   s_data_i,
  output logic                     s_ready_o,
  output logic                     fft_in_valid_o,
  output logic [NFFT_LOG2-1:0]     fft_frame_ptr_o,
  output logic [INPUT_WIDTH-1:0]   fft_real_o,
  output logic                     fft_start_o,
  input  logic                     fft_done_i,
  input  logic                     fft_power_valid_i,
  input  logic [NFFT_LOG2-1:0]     fft_power_ptr_i,
  input  logic [COMPLEX_WIDTH-1:0] fft_power_i,
  output logic                     pw_valid_o,
  output logic [NFFT_LOG2-1:0]     pw_bin_o,
  output logic [COMPLEX_WIDTH-1:0] pw_data_o,
  output logic [FRAME_ID_W-1:0]    pw_frame_o,
  output logic                     pw_last_o,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic                     timeout_o
);

  // Reject parameter sets the sequencing cannot honour.
  if (FRAME_LEN < 1 || FRAME_LEN > NFFT || TIMEOUT_CYCLES < 1 ||
      NFFT != (1 << NFFT_LOG2)) begin : gBadParams
    $error("fft_frame_sequencer: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPad,
    StStart,
    StWaitDone
  } seqState_t;

  localparam logic [NFFT_LOG2-1:0] LastLoadPtr = NFFT_LOG2'(FRAME_LEN - 1);
  localparam logic [NFFT_LOG2-1:0] LastBufPtr  = NFFT_LOG2'(NFFT - 1);
  localparam logic [NFFT_LOG2-1:0] LastBin     = NFFT_LOG2'(NFFT / 2);
  localparam bit                   NeedPad     = (FRAME_LEN < NFFT);

  seqState_t                 state_q;
  logic [NFFT_LOG2-1:0]      wrPtr_q;
  logic [FRAME_ID_W-1:0]     frameId_q;
  logic                      fftInValid_q;
  logic [NFFT_LOG2-1:0]      fftPtr_q;
  logic [INPUT_WIDTH-1:0]    fftReal_q;
  logic                      fftStart_q;
  logic                      frameDone_q;

  logic                      pwValid_q;
  logic [NFFT_LOG2-1:0]      pwBin_q;
  logic [COMPLEX_WIDTH-1:0]  pwData_q;
  logic [FRAME_ID_W-1:0]     pwFrame_q;
  logic                      pwLast_q;
  logic                      pwValid_d;
  logic                      pwLast_d;

  logic                      handshake;
  logic                      wdExpire;

  // Ready is a pure state decode so it drops the cycle after the last
  // accepted sample, when the state has already moved on.
  assign s_ready_o = (state_q == StLoad);
  assign handshake = s_valid_i & s_ready_o;
  assign busy_o    = (state_q != StIdle);

`ifdef FFT_SEQ_WATCHDOG_EN
  localparam int unsigned  WdW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  logic [WdW-1:0] wdCount_q;
  logic           timeout_q;

  // The watchdog fires on the TIMEOUT_CYCLES-th WAIT_DONE cycle that has no
  // done pulse; a done on that same cycle still wins.
  assign wdExpire = (state_q == StWaitDone) && !fft_done_i && (wdCount_q == WdLast);

  // Counts WAIT_DONE cycles; cleared in every other state so each frame
  // gets a fresh budget. The timeout flag stays set until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdCount_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q != StWaitDone) begin
        wdCount_q <= '0;
      end else if (!fft_done_i) begin
        wdCount_q <= wdCount_q + 1'b1;
      end
      if (wdExpire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  assign wdExpire  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Main sequencer. One shared pointer walks 0..NFFT-1: it advances on
  // each accepted sample in LOAD and then continues through the zero pad,
  // so the buffer sees every index exactly once in order. Write strobe,
  // start and frame_done are single-cycle registered pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wrPtr_q      <= '0;
      frameId_q    <= '0;
      fftInValid_q <= 1'b0;
      fftPtr_q     <= '0;
      fftReal_q    <= '0;
      fftStart_q   <= 1'b0;
      frameDone_q  <= 1'b0;
    end else begin
      fftInValid_q <= 1'b0;
      fftStart_q   <= 1'b0;
      frameDone_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (enable_i) begin
            wrPtr_q <= '0;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (handshake) begin
            fftInValid_q <= 1'b1;
            fftPtr_q     <= wrPtr_q;
            fftReal_q    <= s_data_i;
            wrPtr_q      <= wrPtr_q + 1'b1;
            if (wrPtr_q == LastLoadPtr) begin
              state_q <= NeedPad ? StPad : StStart;
            end
          end
        end
        StPad: begin
          fftInValid_q <= 1'b1;
          fftPtr_q     <= wrPtr_q;
          fftReal_q    <= '0;
          wrPtr_q      <= wrPtr_q + 1'b1;
          if (wrPtr_q == LastBufPtr) begin
            state_q <= StStart;
          end
        end
        StStart: begin
          fftStart_q <= 1'b1;
          state_q    <= StWaitDone;
        end
        StWaitDone: begin
          if (fft_done_i) begin
            frameDone_q <= 1'b1;
            frameId_q   <= frameId_q + 1'b1;
            wrPtr_q     <= '0;
            state_q     <= enable_i ? StLoad : StIdle;
          end else if (wdExpire) begin
            // An aborted frame still consumes its ID so downstream never
            // sees two different frames with the same tag.
            frameId_q <= frameId_q + 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Power bins above NFFT/2 are the mirrored half of a real FFT and carry
  // no new information, so they are dropped here.
  always_comb begin
    pwValid_d = fft_power_valid_i && (fft_power_ptr_i <= LastBin);
    pwLast_d  = fft_power_valid_i && (fft_power_ptr_i == LastBin);
  end

  // Power path is independent of the sequencer state: bins are forwarded
  // whenever the FFT presents them, tagged with the frame being computed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwValid_q <= 1'b0;
      pwBin_q   <= '0;
      pwData_q  <= '0;
      pwFrame_q <= '0;
      pwLast_q  <= 1'b0;
    end else begin
      pwValid_q <= pwValid_d;
      pwBin_q   <= fft_power_ptr_i;
      pwData_q  <= fft_power_i;
      pwFrame_q <= frameId_q;
      pwLast_q  <= pwLast_d;
    end
  end

  assign fft_in_valid_o  = fftInValid_q;
  assign fft_frame_ptr_o = fftPtr_q;
  assign fft_real_o      = fftReal_q;
  assign fft_start_o     = fftStart_q;
  assign frame_done_o    = frameDone_q;
  assign pw_valid_o      = pwValid_q;
  assign pw_bin_o        = pwBin_q;
  assign pw_data_o       = pwData_q;
  assign pw_frame_o      = pwFrame_q;
  assign pw_last_o       = pwLast_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_sequencer
//
// Randomized bench for fft_frame_sequencer with a small configuration
// (NFFT=16, FRAME_LEN=10) so that 256+ frames fit comfortably. The
// reference model is a per-frame scoreboard: the samples actually accepted
// followed by zeros must appear as buffer writes 0..NFFT-1, the start pulse
// must follow the last write, and each power bin offered must come back one
// cycle later tagged with the expected frame ID.
// ---------------------------------------------------------------------------
module tb_fft_frame_sequencer;

  localparam int NFFT      = 16;
  localparam int NL        = $clog2(NFFT);
  localparam int FRAME_LEN = 10;
  localparam int IW        = 16;
  localparam int CW        = 32;
  localparam int FIDW      = 8;
  localparam int TO        = 64;

  typedef struct {
    int          cyc;
    int          bin;
    longint      data;
    int          frame;
    int          last;
  } pwRec_t;

  logic          clk;
  logic          rst_n;
  logic          enable_i;
  logic          s_valid_i;
  logic [IW-1:0] s_data_i;
  logic          s_ready_o;
  logic          fft_in_valid_o;
  logic [NL-1:0] fft_frame_ptr_o;
  logic [IW-1:0] fft_real_o;
  logic          fft_start_o;
  logic          fft_done_i;
  logic          fft_power_valid_i;
  logic [NL-1:0] fft_power_ptr_i;
  logic [CW-1:0] fft_power_i;
  logic          pw_valid_o;
  logic [NL-1:0] pw_bin_o;
  logic [CW-1:0] pw_data_o;
  logic [FIDW-1:0] pw_frame_o;
  logic          pw_last_o;
  logic          busy_o;
  logic          frame_done_o;
  logic          timeout_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int     wrCycQ[$];
  int     wrPtrQ[$];
  longint wrDataQ[$];
  int     startQ[$];
  int     doneQ[$];
  pwRec_t pwGotQ[$];
  pwRec_t pwExpQ[$];
  longint expSamples[$];
  int     hsCycQ[$];

  fft_frame_sequencer #(
    .NFFT(NFFT), .NFFT_LOG2(NL), .FRAME_LEN(FRAME_LEN), .INPUT_WIDTH(IW),
    .COMPLEX_WIDTH(CW), .FRAME_ID_W(FIDW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .fft_in_valid_o(fft_in_valid_o), .fft_frame_ptr_o(fft_frame_ptr_o),
    .fft_real_o(fft_real_o), .fft_start_o(fft_start_o), .fft_done_i(fft_done_i),
    .fft_power_valid_i(fft_power_valid_i), .fft_power_ptr_i(fft_power_ptr_i),
    .fft_power_i(fft_power_i), .pw_valid_o(pw_valid_o), .pw_bin_o(pw_bin_o),
    .pw_data_o(pw_data_o), .pw_frame_o(pw_frame_o), .pw_last_o(pw_last_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .timeout_o(timeout_o)
  );

  // Free-running clock and cycle stamp used to time every observation.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic endRun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Advance to the next falling edge and log whatever the DUT shows there.
  task automatic tick();
    pwRec_t r;
    @(negedge clk);
    if (fft_in_valid_o) begin
      wrCycQ.push_back(cyc);
      wrPtrQ.push_back(int'(fft_frame_ptr_o));
      wrDataQ.push_back(longint'(fft_real_o));
    end
    if (fft_start_o) startQ.push_back(cyc);
    if (frame_done_o) doneQ.push_back(cyc);
    if (pw_valid_o) begin
      r.cyc   = cyc;
      r.bin   = int'(pw_bin_o);
      r.data  = longint'(pw_data_o);
      r.frame = int'(pw_frame_o);
      r.last  = int'(pw_last_o);
      pwGotQ.push_back(r);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".s_ready"}, s_ready_o, 0);
    checkOutput({tag, ".in_valid"}, fft_in_valid_o, 0);
    checkOutput({tag, ".ptr"}, fft_frame_ptr_o, 0);
    checkOutput({tag, ".real"}, fft_real_o, 0);
    checkOutput({tag, ".start"}, fft_start_o, 0);
    checkOutput({tag, ".pw_valid"}, pw_valid_o, 0);
    checkOutput({tag, ".pw_bin"}, pw_bin_o, 0);
    checkOutput({tag, ".pw_data"}, pw_data_o, 0);
    checkOutput({tag, ".pw_frame"}, pw_frame_o, 0);
    checkOutput({tag, ".pw_last"}, pw_last_o, 0);
    checkOutput({tag, ".busy"}, busy_o, 0);
    checkOutput({tag, ".frame_done"}, frame_done_o, 0);
    checkOutput({tag, ".timeout"}, timeout_o, 0);
  endtask

  // Present one power bin; only bins up to NFFT/2 are expected back.
  task automatic driveBin(input int p, input int frame);
    pwRec_t r;
    fft_power_valid_i = 1'b1;
    fft_power_ptr_i   = NL'(p);
    fft_power_i       = $urandom;
    if (p <= NFFT / 2) begin
      r.cyc   = cyc + 1;
      r.bin   = p;
      r.data  = longint'(fft_power_i);
      r.frame = frame;
      r.last  = (p == NFFT / 2) ? 1 : 0;
      pwExpQ.push_back(r);
    end
  endtask

  task automatic compareFrame(input int doneCyc, input bit checkContinuous);
    checkOutput("writeCount", wrPtrQ.size(), NFFT);
    for (int i = 0; i < wrPtrQ.size() && i < NFFT; i++) begin
      checkOutput("writePtr", wrPtrQ[i], i);
      if (i < FRAME_LEN) begin
        checkOutput("writeData", wrDataQ[i], expSamples[i]);
        checkOutput("writeCycle", wrCycQ[i], hsCycQ[i] + 1);
      end else begin
        checkOutput("padData", wrDataQ[i], 0);
        checkOutput("padCycle", wrCycQ[i], wrCycQ[i-1] + 1);
      end
    end
    checkOutput("startCount", startQ.size(), 1);
    if (startQ.size() > 0 && wrCycQ.size() > 0)
      checkOutput("startCycle", startQ[0], wrCycQ[wrCycQ.size()-1] + 1);
    if (checkContinuous && startQ.size() > 0)
      checkOutput("startLatency", startQ[0] - hsCycQ[0], NFFT + 1);
    checkOutput("doneCount", doneQ.size(), 1);
    if (doneQ.size() > 0) checkOutput("doneCycle", doneQ[0], doneCyc + 1);
    checkOutput("pwCount", pwGotQ.size(), pwExpQ.size());
    for (int i = 0; i < pwGotQ.size() && i < pwExpQ.size(); i++) begin
      checkOutput("pwCycle", pwGotQ[i].cyc, pwExpQ[i].cyc);
      checkOutput("pwBin", pwGotQ[i].bin, pwExpQ[i].bin);
      checkOutput("pwData", pwGotQ[i].data, pwExpQ[i].data);
      checkOutput("pwFrame", pwGotQ[i].frame, pwExpQ[i].frame);
      checkOutput("pwLast", pwGotQ[i].last, pwExpQ[i].last);
    end
  endtask

  // Runs one frame: load with random bubbles (plus stray done pulses and
  // power bins that must be ignored / forwarded), wait for start, play the
  // FFT's power bins, then optionally signal done and score the frame.
  // resetAt >= 0 pulses reset after that many accepted samples instead.
  task automatic applyStimulus(input int bubblePct, input bit keepEnable, input bit doDone,
                               input int expFrame, input int resetAt, input bit checkContinuous,
                               input int nBins);
    int nAcc;
    int budget;
    int p;
    int doneCyc;
    wrCycQ.delete(); wrPtrQ.delete(); wrDataQ.delete(); startQ.delete(); doneQ.delete();
    pwGotQ.delete(); pwExpQ.delete(); expSamples.delete(); hsCycQ.delete();
    enable_i = 1'b1;
    budget = 0;
    while (!s_ready_o) begin
      budget++;
      if (budget > 8) begin
        checkOutput("readyTimeout", 0, 1);
        endRun();
        return;
      end
      tick();
    end

    nAcc = 0;
    budget = 0;
    while (nAcc < FRAME_LEN) begin
      if (nAcc == resetAt) begin
        s_valid_i = 1'b0; fft_power_valid_i = 1'b0; fft_done_i = 1'b0;
        enable_i = 1'b0; rst_n = 1'b0;
        tick();
        checkAllZero("midReset");
        rst_n = 1'b1;
        return;
      end
      checkOutput("sReadyLoad", s_ready_o, 1);
      checkOutput("busyLoad", busy_o, 1);
      s_valid_i  = ($urandom_range(99) >= bubblePct);
      s_data_i   = IW'($urandom);
      fft_done_i = ($urandom_range(9) == 0);
      if ($urandom_range(99) < 20) driveBin($urandom_range(NFFT - 1), expFrame);
      else fft_power_valid_i = 1'b0;
      if (s_valid_i && s_ready_o) begin
        expSamples.push_back(longint'(s_data_i));
        hsCycQ.push_back(cyc);
        nAcc++;
        enable_i = keepEnable;
      end
      budget++;
      if (budget > 40 * FRAME_LEN) begin
        checkOutput("loadTimeout", nAcc, FRAME_LEN);
        endRun();
        return;
      end
      tick();
    end

    // Keep offering samples: nothing may be accepted until the next frame.
    s_valid_i = 1'b1;
    fft_done_i = 1'b0;
    fft_power_valid_i = 1'b0;
    budget = 0;
    while (startQ.size() == 0) begin
      tick();
      checkOutput("sReadyBlocked", s_ready_o, 0);
      budget++;
      if (budget > NFFT + 4) begin
        checkOutput("startTimeout", startQ.size(), 1);
        endRun();
        return;
      end
    end

    repeat ($urandom_range(3)) begin
      tick();
      checkOutput("sReadyWait", s_ready_o, 0);
    end
    p = 0;
    budget = 0;
    while (p < nBins) begin
      if ($urandom_range(99) < 70) begin
        driveBin(p, expFrame);
        p++;
      end else begin
        fft_power_valid_i = 1'b0;
      end
      tick();
      checkOutput("sReadyWait", s_ready_o, 0);
      checkOutput("busyWait", busy_o, 1);
      budget++;
      if (budget > 20 * NFFT) begin
        checkOutput("binTimeout", p, nBins);
        endRun();
        return;
      end
    end
    fft_power_valid_i = 1'b0;
    if (!doDone) return;

    enable_i   = keepEnable;
    fft_done_i = 1'b1;
    doneCyc    = cyc;
    tick();
    fft_done_i = 1'b0;
    s_valid_i  = 1'b0;
    checkOutput("frameDonePulse", frame_done_o, 1);
    checkOutput("sReadyAfterDone", s_ready_o, keepEnable);
    checkOutput("busyAfterDone", busy_o, keepEnable);
    compareFrame(doneCyc, checkContinuous);
  endtask

  initial begin
    int budget;
    rst_n = 1'b0; enable_i = 1'b0; s_valid_i = 1'b0; s_data_i = '0;
    fft_done_i = 1'b0; fft_power_valid_i = 1'b0; fft_power_ptr_i = '0; fft_power_i = '0;
    repeat (3) tick();
    checkAllZero("reset");
    rst_n = 1'b1;

    $display("[TB] continuous frame, then bubbled frame");
    applyStimulus(0, 1'b1, 1'b1, 0, -1, 1'b1, NFFT);
    applyStimulus(50, 1'b1, 1'b1, 1, -1, 1'b0, NFFT);

    $display("[TB] back-to-back frames through frame ID wrap");
    for (int k = 2; k <= 257; k++)
      applyStimulus(30, (k != 257), 1'b1, k % 256, -1, 1'b0, NFFT);

    $display("[TB] reset in the middle of a load");
    applyStimulus(0, 1'b1, 1'b1, 2, FRAME_LEN / 2, 1'b0, NFFT);
    applyStimulus(20, 1'b0, 1'b1, 0, -1, 1'b0, NFFT);

    $display("[TB] FFT never signals done");
    applyStimulus(0, 1'b0, 1'b0, 1, -1, 1'b0, 4);
`ifdef FFT_SEQ_WATCHDOG_EN
    budget = 0;
    while (!timeout_o && budget < 4 * TO) begin
      tick();
      budget++;
    end
    checkOutput("timeoutSet", timeout_o, 1);
    checkOutput("timeoutCycle", cyc - startQ[0], TO);
    checkOutput("timeoutIdle", busy_o, 0);
    checkOutput("timeoutNoDone", doneQ.size(), 0);
    applyStimulus(10, 1'b0, 1'b1, 2, -1, 1'b0, NFFT);
    checkOutput("timeoutSticky", timeout_o, 1);
`else
    budget = 0;
    repeat (2 * TO) begin
      tick();
      budget++;
    end
    checkOutput("waitCycles", budget, 2 * TO);
    checkOutput("noTimeout", timeout_o, 0);
    checkOutput("stillBusy", busy_o, 1);
    checkOutput("stillBlocked", s_ready_o, 0);
    checkOutput("noDoneWhileStuck", doneQ.size(), 0);
    checkOutput("noExtraWrites", wrPtrQ.size(), NFFT);
`endif
    endRun();
  end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Sequences the radix-2 FFT core in the MFCC chain.
- Accepts a windowed sample stream, writes each frame into the FFT buffer with the frame pointer, and zero-pads the frame to NFFT.
- Issues the start pulse, blocks new input while the FFT computes, and re-emits the power bins tagged with a frame ID and a last-bin flag for the mel filterbank.

Parameters:
- NFFT, 512, FFT size (power of 2).
- NFFT_LOG2, $clog2(NFFT), pointer width.
- FRAME_LEN, 400, real samples per frame; 1 <= FRAME_LEN <= NFFT.
- INPUT_WIDTH, 16, sample width.
- COMPLEX_WIDTH, 32, power sample width.
- FRAME_ID_W, 8, frame tag width.
- TIMEOUT_CYCLES, 8192, watchdog limit in WAIT_DONE (optional feature only).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- enable_i  in  1  allow a new frame to begin
- s_valid_i  in  1  input sample valid
- s_data_i  in  INPUT_WIDTH  signed sample
- s_ready_o  out  1  sequencer accepts a sample
- fft_in_valid_o  out  1  FFT buffer write strobe
- fft_frame_ptr_o  out  NFFT_LOG2  natural-order write index (the FFT bit-reverses it)
- fft_real_o  out  INPUT_WIDTH  write data
- fft_start_o  out  1  one-cycle FFT start pulse
- fft_done_i  in  1  FFT done pulse
- fft_power_valid_i  in  1  power bin valid from FFT
- fft_power_ptr_i  in  NFFT_LOG2  power bin index
- fft_power_i  in  COMPLEX_WIDTH  power value
- pw_valid_o  out  1  tagged power valid
- pw_bin_o  out  NFFT_LOG2  bin index
- pw_data_o  out  COMPLEX_WIDTH  power value
- pw_frame_o  out  FRAME_ID_W  frame tag
- pw_last_o  out  1  asserted with bin NFFT/2
- busy_o  out  1  state != IDLE
- frame_done_o  out  1  one-cycle pulse per completed frame
- timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset: state IDLE; frame ID 0; every output 0.
- State IDLE:
  - s_ready_o = 0.
  - If enable_i = 1, go to LOAD next cycle with sample count 0.
- State LOAD:
  - s_ready_o = 1 combinationally.
  - On each handshake (s_valid_i & s_ready_o), the next cycle drives fft_in_valid_o = 1, fft_frame_ptr_o = count, fft_real_o = s_data_i. This is a 1-cycle registered latency.
  - No handshake means fft_in_valid_o = 0 the next cycle; bubbles are allowed.
  - On the FRAME_LEN-th handshake, s_ready_o drops in the next cycle.
  - Next state is PAD if FRAME_LEN < NFFT, else START.
- State PAD:
  - s_ready_o = 0.
  - One write per cycle: fft_in_valid_o = 1, ptr = FRAME_LEN .. NFFT-1, data 0.
  - After ptr NFFT-1, go to START.
- State START:
  - fft_start_o = 1 for exactly one cycle, issued the cycle after the final buffer write.
  - Then go to WAIT_DONE.
- State WAIT_DONE:
  - s_ready_o = 0 and fft_in_valid_o = 0; no write may collide with butterfly writeback.
  - On fft_done_i: frame_done_o pulses next cycle and the frame ID increments, wrapping modulo 2^FRAME_ID_W.
  - After done, go to LOAD if enable_i = 1, else IDLE. Frames run back-to-back with no idle cycle.
- enable_i is sampled only in IDLE and at done. Deasserting it mid-frame completes the current frame.
- Power path, in any state:
  - pw_* are registered copies of fft_power_* with 1-cycle latency.
  - pw_frame_o = ID of the frame being computed.
  - pw_last_o = fft_power_valid_i & (fft_power_ptr_i == NFFT/2).
  - Bins with ptr > NFFT/2 are dropped (pw_valid_o = 0).
- fft_done_i outside WAIT_DONE is ignored. A power valid outside WAIT_DONE is still forwarded.
- Reset mid-operation returns to IDLE immediately. Partial frame data is discarded and no write/start is issued after reset.

Optional Feature:
- Macro FFT_SEQ_WATCHDOG_EN.
- When defined:
  - A cycle counter runs in WAIT_DONE.
  - If it reaches TIMEOUT_CYCLES without fft_done_i: set timeout_o (sticky until reset), go to IDLE without frame_done_o, and increment the frame ID.
- When undefined:
  - timeout_o is tied 0, no counter is synthesized, and WAIT_DONE waits indefinitely.

Test Plan:
- Continuous s_valid_i, FRAME_LEN = 400, NFFT = 512: 400 writes with ptr 0..399 and data matching the inputs, then 112 zero writes with ptr 400..511, then fft_start_o exactly once at cycle 513 after the first handshake.
- Random s_valid_i bubbles (50%): write order and data unchanged; fft_frame_ptr_o has no gaps or duplicates; s_ready_o = 0 during PAD/WAIT_DONE.
- FFT model emitting power ptr 0..256 then done: pw_valid_o appears 1 cycle after each input; pw_last_o only at bin 256; pw_frame_o = 0; frame_done_o pulses once and the next frame is tagged 1.
- enable_i held high for 256 frames: pw_frame_o wraps 255 -> 0; no idle cycle between done and the next LOAD.
- rst_n low for 1 cycle at sample 200: all outputs 0 the next cycle; the next frame restarts at ptr 0 with frame ID 0.
- With FFT_SEQ_WATCHDOG_EN and TIMEOUT_CYCLES = 64, FFT never signals done: timeout_o = 1 after 64 WAIT_DONE cycles and state is IDLE. Without the macro, the sequencer stays busy and timeout_o = 0.
